// File: rtl/bin_frame_packer_if.sv
// Purpose: bit-stream input and packed-word output bundle for bin_frame_packer.
//   slave  (design side): iEN, iDATA, iSOF, iREADY in; oDATA, oEN, oLAST, oOVF, oBUSY out
//   master (source/sink side): the reverse directions
// Optional: BIN_FRAME_PACKER_POPCNT_EN adds oCNT (CW bits, per-frame 1-bit count).
interface bin_frame_packer_if #(
    parameter int unsigned WL = 16
`ifdef BIN_FRAME_PACKER_POPCNT_EN
    , parameter int unsigned CW = 11
`endif
);
    logic          iEN;
    logic          iDATA;
    logic          iSOF;
    logic          iREADY;
    logic [WL-1:0] oDATA;
    logic          oEN;
    logic          oLAST;
    logic          oOVF;
    logic          oBUSY;
`ifdef BIN_FRAME_PACKER_POPCNT_EN
    logic [CW-1:0] oCNT;

    modport master (
        output iEN, iDATA, iSOF, iREADY,
        input  oDATA, oEN, oLAST, oOVF, oBUSY, oCNT
    );
    modport slave (
        input  iEN, iDATA, iSOF, iREADY,
        output oDATA, oEN, oLAST, oOVF, oBUSY, oCNT
    );
`else
    modport master (
        output iEN, iDATA, iSOF, iREADY,
        input  oDATA, oEN, oLAST, oOVF, oBUSY
    );
    modport slave (
        input  iEN, iDATA, iSOF, iREADY,
        output oDATA, oEN, oLAST, oOVF, oBUSY
    );
`endif
endinterface

// File: rtl/bin_frame_packer.sv
// Purpose: packs 1-bit threshold decisions LSB-first into WL-bit words, tags the last
//   word of each frame, buffers words in an FD-deep FIFO and presents the FIFO head
//   on a valid/ready port.  All outputs are registered.
// Ports:
//   iCLK   clock (rising edge)
//   iRSTn  asynchronous active-low reset
//   bus    bin_frame_packer_if.slave: iEN/iDATA/iSOF bit stream, iREADY downstream
//          ready; oDATA/oEN/oLAST head word, oOVF sticky drop flag, oBUSY activity
// Optional: define BIN_FRAME_PACKER_POPCNT_EN to add oCNT, the number of 1-bits in the
//   frame, carried with the frame's last word.
// Assumes WL >= 2, FRAME_BITS a multiple of WL, FD a power of 2 >= 2.
module bin_frame_packer #(
    parameter int unsigned WL         = 16,
    parameter int unsigned FRAME_BITS = 1024,
    parameter int unsigned FD         = 4
) (
    input logic             iCLK,
    input logic             iRSTn,
    bin_frame_packer_if.slave bus
);
    localparam int unsigned WCW  = $clog2(WL);
    localparam int unsigned FCW  = $clog2(FRAME_BITS);
    localparam int unsigned PW   = $clog2(FD);
    localparam int unsigned OCCW = $clog2(FD + 1);
`ifdef BIN_FRAME_PACKER_POPCNT_EN
    localparam int unsigned CW   = $clog2(FRAME_BITS + 1);
`endif

    typedef enum logic {IDLE, PACK} state_t;

    state_t          state_q, state_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic [FCW-1:0]  fcnt_q, fcnt_d;
    logic [WL-1:0]   word_q, word_d;

    logic [WCW-1:0]  pos;
    logic [FCW-1:0]  fpos;
    logic [WL-1:0]   word_new;
    logic            accept;
    logic            push;
    logic [WL-1:0]   push_word;
    logic            push_last;

    logic [WL-1:0]   mem_data [FD];
    logic            mem_last [FD];
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [OCCW-1:0] occ_q, occ_d, after_pop;
    logic            pop, full, wr_en;
    logic [WL-1:0]   head_data;
    logic            head_last;

    logic [WL-1:0]   data_q, data_d;
    logic            en_q, en_d;
    logic            last_q, last_d;
    logic            ovf_q, ovf_d;
    logic            busy_q, busy_d;

`ifdef BIN_FRAME_PACKER_POPCNT_EN
    logic [CW-1:0]   ones_q, ones_d, ones_new;
    logic [CW-1:0]   push_cnt;
    logic [CW-1:0]   mem_cnt [FD];
    logic [CW-1:0]   head_cnt;
    logic [CW-1:0]   cnt_q, cnt_d;
`endif

    // Packer FSM: next state, word/frame counters and word push.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        fcnt_d    = fcnt_q;
        word_d    = word_q;
        push      = 1'b0;
        push_word = '0;
        push_last = 1'b0;
`ifdef BIN_FRAME_PACKER_POPCNT_EN
        ones_d    = ones_q;
        push_cnt  = '0;
        ones_new  = (bus.iSOF ? '0 : ones_q) + CW'(bus.iDATA);
`endif
        // An SOF bit always lands at position 0 of a fresh word and frame.
        pos      = bus.iSOF ? '0 : wcnt_q;
        fpos     = bus.iSOF ? '0 : fcnt_q;
        word_new = (bus.iSOF ? '0 : word_q) | (WL'(bus.iDATA) << pos);
        accept   = bus.iEN && (bus.iSOF || state_q == PACK);

        if (accept) begin
            // Early SOF closes the truncated frame with its zero-padded partial word.
            if (bus.iSOF && state_q == PACK && wcnt_q != '0) begin
                push      = 1'b1;
                push_word = word_q;
                push_last = 1'b1;
`ifdef BIN_FRAME_PACKER_POPCNT_EN
                push_cnt  = ones_q;
`endif
            end
`ifdef BIN_FRAME_PACKER_POPCNT_EN
            ones_d = ones_new;
`endif
            if (pos == WCW'(WL - 1)) begin
                push      = 1'b1;
                push_word = word_new;
                push_last = (fpos == FCW'(FRAME_BITS - 1));
`ifdef BIN_FRAME_PACKER_POPCNT_EN
                push_cnt  = ones_new;
`endif
                word_d    = '0;
                wcnt_d    = '0;
            end else begin
                word_d    = word_new;
                wcnt_d    = pos + WCW'(1);
            end
            if (fpos == FCW'(FRAME_BITS - 1)) begin
                state_d = IDLE;
                fcnt_d  = '0;
            end else begin
                state_d = PACK;
                fcnt_d  = fpos + FCW'(1);
            end
        end
    end

    // FIFO bookkeeping and the next registered head/status outputs.
    always_comb begin
        pop       = en_q && bus.iREADY;
        full      = (occ_q == OCCW'(FD));
        wr_en     = push && (!full || pop);
        ovf_d     = ovf_q || (push && full && !pop);
        occ_d     = occ_q + OCCW'(wr_en) - OCCW'(pop);
        rd_d      = rd_q + PW'(pop);
        wr_d      = wr_q + PW'(wr_en);
        after_pop = occ_q - OCCW'(pop);
        // When only the incoming word will be left, it bypasses the memory read.
        head_data = (after_pop == '0) ? push_word : mem_data[rd_d];
        head_last = (after_pop == '0) ? push_last : mem_last[rd_d];
        en_d      = (occ_d != '0);
        data_d    = en_d ? head_data : '0;
        last_d    = en_d && head_last;
        busy_d    = (state_d == PACK) || en_d;
`ifdef BIN_FRAME_PACKER_POPCNT_EN
        head_cnt  = (after_pop == '0) ? push_cnt : mem_cnt[rd_d];
        cnt_d     = last_d ? head_cnt : '0;
`endif
    end

    // FSM state register.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, FIFO pointers and output registers.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            wcnt_q <= '0;
            fcnt_q <= '0;
            word_q <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            occ_q  <= '0;
            data_q <= '0;
            en_q   <= 1'b0;
            last_q <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            fcnt_q <= fcnt_d;
            word_q <= word_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            occ_q  <= occ_d;
            data_q <= data_d;
            en_q   <= en_d;
            last_q <= last_d;
            ovf_q  <= ovf_d;
            busy_q <= busy_d;
        end
    end

    // FIFO storage; contents are don't-care until the pointers mark them valid.
    always_ff @(posedge iCLK) begin
        if (wr_en) begin
            mem_data[wr_q] <= push_word;
            mem_last[wr_q] <= push_last;
`ifdef BIN_FRAME_PACKER_POPCNT_EN
            mem_cnt[wr_q]  <= push_cnt;
`endif
        end
    end

`ifdef BIN_FRAME_PACKER_POPCNT_EN
    // Running 1-bit count of the current frame and the registered oCNT.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            ones_q <= '0;
            cnt_q  <= '0;
        end else begin
            ones_q <= ones_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.oCNT = cnt_q;
`endif

    assign bus.oDATA = data_q;
    assign bus.oEN   = en_q;
    assign bus.oLAST = last_q;
    assign bus.oOVF  = ovf_q;
    assign bus.oBUSY = busy_q;
endmodule
